// File: rtl/uart_pkg.sv
// Shared definitions for the AXI-stream UART transmitter: state encoding,
// default bit period and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // 12 MHz / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

    // Clock cycles of non-idle line activity for one frame.
    function automatic int unsigned frame_cycles(
        input int unsigned data_width,
        input int unsigned clks_per_bit,
        input int unsigned stop_bits,
        input bit          parity_en
    );
        return (32'd1 + data_width + stop_bits + (parity_en ? 32'd1 : 32'd0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/axis_uart_tx_if.sv
// AXI-stream byte handshake between the FIFO stage and the UART transmitter.
interface axis_uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] idata;
    logic                  ivalid;
    logic                  iready;

    modport master (output idata, output ivalid, input  iready);
    modport slave  (input  idata, input  ivalid, output iready);
endinterface

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps, and restarts from 0 on request.
module baud_counter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic resetn,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_count;

    // Free-running period counter, reloaded on every FSM state entry
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (restart || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick = (r_count == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-stream to UART serialiser: start bit, DATA_WIDTH bits LSB first,
// optional even parity, STOP_BITS stop bits.
// Optional parity bit enabled by defining AXIS_UART_TX_PARITY_EN.
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic           clock,
    input  logic           resetn,
    axis_uart_tx_if.slave  s_axis,
    output logic           txd,
    output logic           busy
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    uart_state_e           r_state,   w_state_next;
    logic [DATA_WIDTH-1:0] r_shift,   w_shift_next;
    logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic                  r_txd,     w_txd_next;
    logic                  r_iready;
    logic                  r_busy;
    logic                  w_tick;
    logic                  w_restart;
`ifdef AXIS_UART_TX_PARITY_EN
    logic                  r_parity,  w_parity_next;
`endif

    baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock   (clock),
        .resetn  (resetn),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // State, datapath and registered line/handshake outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
            r_iready  <= 1'b1;
            r_busy    <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_txd     <= w_txd_next;
            // Track the state register one-for-one; no path from ivalid
            r_iready  <= (w_state_next == ST_IDLE);
            r_busy    <= (w_state_next != ST_IDLE);
`ifdef AXIS_UART_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    // Next-state, shift/bit-count update and next line level
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_txd_next     = 1'b1;
`ifdef AXIS_UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif

        case (r_state)
            ST_IDLE: begin
                if (s_axis.ivalid && r_iready) begin
                    w_state_next = ST_START;
                    w_shift_next = s_axis.idata;
`ifdef AXIS_UART_TX_PARITY_EN
                    w_parity_next = ^s_axis.idata;
`endif
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next   = ST_DATA;
                    w_bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
`ifdef AXIS_UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef AXIS_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Bit counter doubles as the stop-bit counter
                if (w_tick) begin
                    if (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
                        w_state_next   = ST_IDLE;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Line level is a function of where the FSM is heading
        case (w_state_next)
            ST_START:  w_txd_next = 1'b0;
            ST_DATA:   w_txd_next = w_shift_next[0];
`ifdef AXIS_UART_TX_PARITY_EN
            ST_PARITY: w_txd_next = w_parity_next;
`endif
            default:   w_txd_next = 1'b1;
        endcase
    end

    assign w_restart     = (w_state_next != r_state);
    assign txd           = r_txd;
    assign busy          = r_busy;
    assign s_axis.iready = r_iready;

endmodule

// File: tb/tb_axis_uart_tx.sv
// Self-checking bench for axis_uart_tx (CLKS_PER_BIT=4, DATA_WIDTH=8).
// Build with AXIS_UART_TX_PARITY_EN defined to cover the parity variant (STOP_BITS=2).
module tb_axis_uart_tx;
    import uart_pkg::*;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef AXIS_UART_TX_PARITY_EN
    localparam int SB       = 2;
    localparam bit PAR      = 1'b1;
    localparam int NLEV     = 12;
    localparam int EXP_END  = 49;   // 48-cycle frame, iready back on cycle 49
`else
    localparam int SB       = 1;
    localparam bit PAR      = 1'b0;
    localparam int NLEV     = 10;
    localparam int EXP_END  = 41;   // 40-cycle frame, iready back on cycle 41
`endif
    localparam int FLEN = int'(frame_cycles(DW, CPB, SB, PAR));

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic txd;
    logic busy;

    axis_uart_tx_if #(.DATA_WIDTH(DW)) axis ();

    axis_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .s_axis (axis),
        .txd    (txd),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_hs     = 0;
    int end_k    = 0;
    bit rec_txd [0:127];
    bit exp_a5  [NLEV];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Line level at position idx of a frame carrying d
    function automatic bit frame_bit(input logic [DW-1:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
`ifdef AXIS_UART_TX_PARITY_EN
        if (idx == DW + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Reference model: a frame occupies FLEN cycles after an idle-time ivalid
    bit            m_active = 1'b0;
    int            m_pos    = 0;
    logic [DW-1:0] m_data   = '0;

    initial forever begin
        @(posedge clock or negedge resetn);
        if (!resetn) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (!m_active) begin
            if (axis.ivalid) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_data   = axis.idata;
            end
        end else begin
            m_pos++;
            if (m_pos == FLEN) m_active = 1'b0;
        end
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clock);
        check("cyc_txd",    int'(txd),         int'(m_active ? frame_bit(m_data, m_pos / CPB) : 1'b1));
        check("cyc_iready", int'(axis.iready), int'(!m_active));
        check("cyc_busy",   int'(busy),        int'(m_active));
    end

    // Offer d until accepted; returns one step into cycle 1 of the frame
    task automatic hs_wait(input logic [DW-1:0] d, input bit hold);
        bit hs = 1'b0;
        axis.idata  = d;
        axis.ivalid = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            hs = axis.iready;
            @(posedge clock);
            #1;
        end
        check("handshake", int'(hs), 1);
        t_hs = cyc;
        if (!hold) axis.ivalid = 1'b0;
    endtask

    // Record txd per cycle until iready returns
    task automatic run_frame();
        bit done = 1'b0;
        end_k = 0;
        for (int k = 1; k < 120 && !done; k++) begin
            rec_txd[k] = txd;
            if (axis.iready) begin
                end_k = k;
                done  = 1'b1;
            end else begin
                @(posedge clock);
                #1;
            end
        end
        check("frame_end", end_k, EXP_END);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !axis.iready; i++) begin
            @(posedge clock);
            #1;
        end
        check("idle_wait", int'(axis.iready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int t0, t1, t2;
        axis.idata  = '0;
        axis.ivalid = 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

        // Reset values, and their persistence when idle
        repeat (3) @(posedge clock);
        #1;
        check("rst_txd",    int'(txd),         1);
        check("rst_iready", int'(axis.iready), 1);
        check("rst_busy",   int'(busy),        0);
        resetn = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("idle_txd",    int'(txd),         1);
        check("idle_iready", int'(axis.iready), 1);
        check("idle_busy",   int'(busy),        0);

        // Single frame 0xA5
        hs_wait(8'hA5, 1'b0);
        run_frame();
        for (int i = 0; i < NLEV; i++)
            for (int j = 1; j <= CPB; j++)
                check("a5_level", int'(rec_txd[i*CPB + j]), int'(exp_a5[i]));

        // Back-to-back with ivalid held high
        hs_wait(8'h00, 1'b1);
        t0 = t_hs;
        hs_wait(8'hFF, 1'b1);
        t1 = t_hs;
        hs_wait(8'h55, 1'b0);
        t2 = t_hs;
        run_frame();
        check("b2b_period1", t1 - t0, EXP_END);
        check("b2b_period2", t2 - t1, EXP_END);

        // idata changes mid-frame with ivalid high; frame keeps 0x96
        hs_wait(8'h96, 1'b1);
        @(posedge clock);
        #1;
        axis.idata = 8'hFF;
        repeat (4) begin @(posedge clock); #1; end
        check("stab_bit0", int'(txd), 0);
        repeat (13) begin @(posedge clock); #1; end
        check("stab_bit3", int'(txd), 0);
        axis.ivalid = 1'b0;
        wait_idle();

        // Reset during data bit 3
        hs_wait(8'hC3, 1'b0);
        repeat (16) begin @(posedge clock); #1; end
        check("pre_rst_busy", int'(busy), 1);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_txd",    int'(txd),         1);
        check("midrst_iready", int'(axis.iready), 1);
        check("midrst_busy",   int'(busy),        0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        hs_wait(8'h3C, 1'b0);
        run_frame();
        check("x3c_bit0", int'(rec_txd[5]),  0);
        check("x3c_bit2", int'(rec_txd[13]), 1);

`ifdef AXIS_UART_TX_PARITY_EN
        // Parity bit occupies cycles 37..40
        hs_wait(8'h07, 1'b0);
        run_frame();
        for (int k = 37; k <= 40; k++) check("par_07", int'(rec_txd[k]), 1);
        hs_wait(8'h03, 1'b0);
        run_frame();
        for (int k = 37; k <= 40; k++) check("par_03", int'(rec_txd[k]), 0);
`endif

        repeat (3) @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
